// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg : shared state encodings, default timings and commands for the LCD
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP_HI = 3'd1,
    ST_PULSE_HI = 3'd2,
    ST_GAP      = 3'd3,
    ST_SETUP_LO = 3'd4,
    ST_PULSE_LO = 3'd5,
    ST_WAIT     = 3'd6,
    ST_DONE     = 3'd7
  } lcd_state_t;

  // Default timings at 50 MHz, shared with the power-on init controller.
  localparam int unsigned LCD_SETUP_CYCLES     = 2;
  localparam int unsigned LCD_ENABLE_CYCLES    = 12;
  localparam int unsigned LCD_GAP_CYCLES       = 50;
  localparam int unsigned LCD_WAIT_CYCLES      = 2000;
  localparam int unsigned LCD_LONG_WAIT_CYCLES = 82000;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  function automatic logic [31:0] lcd_count_load(input int unsigned cycles);
    return 32'(cycles - 1);
  endfunction

  // 0x03 decodes as return-home on the controller, so it needs the long wait too.
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == LCD_CMD_CLEAR) || (b == LCD_CMD_HOME) || (b == 8'h03));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_nibble_writer.sv
// ---------------------------------------------------------------------------
// lcd_nibble_writer : setup + LCD_E pulse sequencing for one nibble, shared by
// the high and low halves of a byte. Returns setup/pulse done strobes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcd_nibble_writer
  import lcd_pkg::*;
(
  input  lcd_state_t i_state,
  input  lcd_state_t i_next_state,
  input  logic       i_count_zero,
  input  logic [7:0] i_byte,
  output logic       o_setup_done,
  output logic       o_pulse_done,
  output logic       o_enable_next,
  output logic [3:0] o_nibble_next
);

  always_comb begin
    o_setup_done  = i_count_zero && ((i_state == ST_SETUP_HI) || (i_state == ST_SETUP_LO));
    o_pulse_done  = i_count_zero && ((i_state == ST_PULSE_HI) || (i_state == ST_PULSE_LO));
    o_enable_next = (i_next_state == ST_PULSE_HI) || (i_next_state == ST_PULSE_LO);
    // The bus holds each nibble through the cycle after its pulse (GAP / WAIT).
    case (i_next_state)
      ST_SETUP_HI, ST_PULSE_HI, ST_GAP:  o_nibble_next = i_byte[7:4];
      ST_SETUP_LO, ST_PULSE_LO, ST_WAIT: o_nibble_next = i_byte[3:0];
      default:                           o_nibble_next = 4'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lcd_byte_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_byte_scheduler : byte write sequencer for the 4-bit character LCD.
// Optional macro LCD_LONG_CMD_WAIT_EN: long execution wait for clear/home.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcd_byte_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES     = LCD_SETUP_CYCLES,
  parameter int unsigned ENABLE_CYCLES    = LCD_ENABLE_CYCLES,
  parameter int unsigned GAP_CYCLES       = LCD_GAP_CYCLES,
  parameter int unsigned WAIT_CYCLES      = LCD_WAIT_CYCLES,
  parameter int unsigned LONG_WAIT_CYCLES = LCD_LONG_WAIT_CYCLES
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iInitDone,
  input  logic       iRequest,
  input  logic       iRegisterSelect,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic [3:0] oLCD_Data
);

  lcd_state_t  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [3:0]  lcd_data_q, lcd_data_d;

  logic        count_zero;
  logic        setup_done;
  logic        pulse_done;
  logic        enable_next;
  logic [3:0]  nibble_next;
  logic [31:0] wait_load;

  assign count_zero = (count_q == 32'd0);

`ifdef LCD_LONG_CMD_WAIT_EN
  assign wait_load = lcd_is_long_cmd(rs_q, byte_q) ? lcd_count_load(LONG_WAIT_CYCLES)
                                                   : lcd_count_load(WAIT_CYCLES);
`else
  logic unused_long_wait;
  assign unused_long_wait = ^LONG_WAIT_CYCLES;
  assign wait_load        = lcd_count_load(WAIT_CYCLES);
`endif

  lcd_nibble_writer u_nibble_writer (
    .i_state       (state_q),
    .i_next_state  (state_d),
    .i_count_zero  (count_zero),
    .i_byte        (byte_d),
    .o_setup_done  (setup_done),
    .o_pulse_done  (pulse_done),
    .o_enable_next (enable_next),
    .o_nibble_next (nibble_next)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_zero ? 32'd0 : count_q - 32'd1;
    byte_d  = byte_q;
    rs_d    = rs_q;
    case (state_q)
      ST_IDLE: begin
        if (iRequest && ready_q) begin
          state_d = ST_SETUP_HI;
          count_d = lcd_count_load(SETUP_CYCLES);
          byte_d  = iData;
          rs_d    = iRegisterSelect;
        end
      end
      ST_SETUP_HI: if (setup_done) begin
        state_d = ST_PULSE_HI;
        count_d = lcd_count_load(ENABLE_CYCLES);
      end
      ST_PULSE_HI: if (pulse_done) begin
        state_d = ST_GAP;
        count_d = lcd_count_load(GAP_CYCLES);
      end
      ST_GAP: if (count_zero) begin
        state_d = ST_SETUP_LO;
        count_d = lcd_count_load(SETUP_CYCLES);
      end
      ST_SETUP_LO: if (setup_done) begin
        state_d = ST_PULSE_LO;
        count_d = lcd_count_load(ENABLE_CYCLES);
      end
      ST_PULSE_LO: if (pulse_done) begin
        state_d = ST_WAIT;
        count_d = wait_load;
      end
      ST_WAIT: if (count_zero) begin
        state_d = ST_DONE;
        count_d = 32'd0;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 32'd0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_d    = iInitDone && (state_d == ST_IDLE);
    done_d     = (state_d == ST_DONE);
    lcd_e_d    = enable_next;
    lcd_rs_d   = rs_d && (state_d != ST_IDLE) && (state_d != ST_DONE);
    lcd_data_d = nibble_next;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      count_q    <= 32'd0;
      byte_q     <= 8'h00;
      rs_q       <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_q     <= byte_d;
      rs_q       <= rs_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
    end
  end

  assign oReady              = ready_q;
  assign oDone               = done_q;
  assign oLCD_Enabled        = lcd_e_q;
  assign oLCD_RegisterSelect = lcd_rs_q;
  assign oLCD_ReadWrite      = 1'b0;
  assign oLCD_Data           = lcd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_byte_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lcd_byte_scheduler : directed bench for lcd_byte_scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_byte_scheduler;

`ifdef LCD_LONG_CMD_WAIT_EN
  localparam int IDLE_HOLD = 1000;
`else
  localparam int IDLE_HOLD = 10000;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       init_done, req, rs;
  logic [7:0] data;
  logic       ready, done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  logic       f_req, f_rs;
  logic [7:0] f_data;
  logic       f_ready, f_done, f_e, f_lrs, f_rw;
  logic [3:0] f_d;

  always #10 Clock = ~Clock;

  lcd_byte_scheduler dut (
    .Clock(Clock), .Reset(Reset), .iInitDone(init_done), .iRequest(req),
    .iRegisterSelect(rs), .iData(data), .oReady(ready), .oDone(done),
    .oLCD_Enabled(lcd_e), .oLCD_RegisterSelect(lcd_rs), .oLCD_ReadWrite(lcd_rw),
    .oLCD_Data(lcd_d)
  );

  // Short-timing instance so a long random byte stream stays cheap.
  lcd_byte_scheduler #(
    .SETUP_CYCLES(2), .ENABLE_CYCLES(3), .GAP_CYCLES(2), .WAIT_CYCLES(3),
    .LONG_WAIT_CYCLES(5)
  ) dut_fast (
    .Clock(Clock), .Reset(Reset), .iInitDone(1'b1), .iRequest(f_req),
    .iRegisterSelect(f_rs), .iData(f_data), .oReady(f_ready), .oDone(f_done),
    .oLCD_Enabled(f_e), .oLCD_RegisterSelect(f_lrs), .oLCD_ReadWrite(f_rw),
    .oLCD_Data(f_d)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bus-stability and nibble-order monitors.
  int         viol = 0, f_rises = 0, f_dones = 0, nib_err = 0;
  logic       p_rst = 1'b1, p_e = 1'b0, pf_e = 1'b0, p_rs = 1'b0, pf_rs = 1'b0;
  logic [3:0] p_d = 4'h0, pf_d = 4'h0;
  logic [3:0] exp_nib [200];

  always @(negedge Clock) begin
    if (!p_rst && !Reset) begin
      if (p_e && ((lcd_d !== p_d) || (lcd_rs !== p_rs))) viol <= viol + 1;
      if (pf_e && ((f_d !== pf_d) || (f_lrs !== pf_rs))) viol <= viol + 1;
      if (lcd_rw !== 1'b0 || f_rw !== 1'b0) viol <= viol + 1;
    end
    if (!pf_e && f_e) begin
      if (f_rises < 200 && f_d !== exp_nib[f_rises]) nib_err <= nib_err + 1;
      f_rises <= f_rises + 1;
    end
    if (f_done) f_dones <= f_dones + 1;
    p_rst <= Reset;
    p_e   <= lcd_e;  p_d  <= lcd_d; p_rs  <= lcd_rs;
    pf_e  <= f_e;    pf_d <= f_d;   pf_rs <= f_lrs;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Returns one cycle after the accepting edge (cycle k+1).
  task automatic wait_accept(input string tag);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge Clock);
      if (ready === 1'b1) got = 1;
    end
    chk({tag, "_accept"}, 32'(got), 32'd1);
    tick();
  endtask

  // Cycle-by-cycle expected waveform for one byte, n = cycles after accept.
  task automatic check_byte(input string tag, input logic [7:0] b, input logic r, input int w);
    int bad_e = 0, bad_d = 0, bad_rs = 0, bad_done = 0, bad_rdy = 0;
    int last  = 80 + w;
    for (int n = 1; n <= last; n++) begin
      logic       ee, ers, edn, erd;
      logic [3:0] ed;
      ee  = (n >= 3 && n <= 14) || (n >= 67 && n <= 78);
      ed  = (n <= 64) ? b[7:4] : ((n <= 78 + w) ? b[3:0] : 4'h0);
      ers = (n <= 78 + w) ? r : 1'b0;
      edn = (n == 79 + w);
      erd = (n == last) ? init_done : 1'b0;
      if (lcd_e  !== ee)  bad_e++;
      if (lcd_d  !== ed)  bad_d++;
      if (lcd_rs !== ers) bad_rs++;
      if (done   !== edn) bad_done++;
      if (ready  !== erd) bad_rdy++;
      if (n < last) tick();
    end
    chk({tag, "_lcd_e_bad_cycles"}, 32'(bad_e), 32'd0);
    chk({tag, "_data_bad_cycles"},  32'(bad_d), 32'd0);
    chk({tag, "_rs_bad_cycles"},    32'(bad_rs), 32'd0);
    chk({tag, "_done_bad_cycles"},  32'(bad_done), 32'd0);
    chk({tag, "_ready_bad_cycles"}, 32'(bad_rdy), 32'd0);
  endtask

  initial begin
    bit         e_seen, r_seen, d_seen;
    int         f_to;
    logic [7:0] b;

    Reset = 1'b1; init_done = 1'b0; req = 1'b0; rs = 1'b0; data = 8'h00;
    f_req = 1'b0; f_rs = 1'b0; f_data = 8'h00;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_lcd_e", 32'(lcd_e), 32'd0);
    chk("rst_rs",    32'(lcd_rs), 32'd0);
    chk("rst_data",  32'(lcd_d), 32'd0);
    chk("rst_rw",    32'(lcd_rw), 32'd0);

    // Held request with init not done must be ignored.
    Reset = 1'b0; req = 1'b1; data = 8'h41; rs = 1'b1;
    e_seen = 0; r_seen = 0;
    repeat (IDLE_HOLD) begin
      tick();
      if (lcd_e === 1'b1) e_seen = 1;
      if (ready === 1'b1) r_seen = 1;
    end
    chk("gate_ready_seen", 32'(r_seen), 32'd0);
    chk("gate_lcd_e_seen", 32'(e_seen), 32'd0);

    init_done = 1'b1;
    wait_accept("b41");
    req = 1'b0;
    check_byte("b41", 8'h41, 1'b1, 2000);

    // Two queued commands: the second is taken exactly 2080 cycles later.
    rs = 1'b0; data = 8'h28; req = 1'b1;
    wait_accept("q28");
    data = 8'h0C;
    check_byte("q28", 8'h28, 1'b0, 2000);
    tick();
    req = 1'b0;
    check_byte("q0c", 8'h0C, 1'b0, 2000);

    // Reset inside the high-nibble pulse.
    rs = 1'b1; data = 8'h41; req = 1'b1;
    wait_accept("rmid");
    req = 1'b0;
    repeat (4) tick();
    chk("rmid_pre_lcd_e", 32'(lcd_e), 32'd1);
    Reset = 1'b1;
    tick();
    chk("rmid_lcd_e", 32'(lcd_e), 32'd0);
    chk("rmid_data",  32'(lcd_d), 32'd0);
    chk("rmid_rs",    32'(lcd_rs), 32'd0);
    chk("rmid_done",  32'(done), 32'd0);
    Reset = 1'b0;
    d_seen = 0;
    repeat (3) begin
      tick();
      if (done === 1'b1 || lcd_e === 1'b1) d_seen = 1;
    end
    chk("rmid_no_activity", 32'(d_seen), 32'd0);
    chk("rmid_ready_after", 32'(ready), 32'd1);

`ifdef LCD_LONG_CMD_WAIT_EN
    rs = 1'b0; data = 8'h01; req = 1'b1;
    wait_accept("clr");
    req = 1'b0;
    check_byte("clr", 8'h01, 1'b0, 82000);
    rs = 1'b1; data = 8'h01; req = 1'b1;
    wait_accept("d01");
    req = 1'b0;
    check_byte("d01", 8'h01, 1'b1, 2000);
`endif

    // 100 random bytes through the short-timing instance.
    f_to = 0;
    for (int i = 0; i < 100; i++) begin
      bit got;
      b = 8'($urandom);
      exp_nib[2*i]     = b[7:4];
      exp_nib[2*i + 1] = b[3:0];
      f_data = b; f_rs = 1'($urandom); f_req = 1'b1;
      got = 0;
      for (int j = 0; j < 100 && !got; j++) begin
        @(negedge Clock);
        if (f_ready === 1'b1) got = 1;
      end
      if (!got) f_to++;
      tick();
      f_req = 1'b0;
      got = 0;
      for (int j = 0; j < 100 && !got; j++) begin
        @(negedge Clock);
        if (f_done === 1'b1) got = 1;
      end
      if (!got) f_to++;
    end
    repeat (5) tick();
    chk("rand_timeouts",     32'(f_to), 32'd0);
    chk("rand_e_rises",      32'(f_rises), 32'd200);
    chk("rand_done_pulses",  32'(f_dones), 32'd100);
    chk("rand_nibble_order", 32'(nib_err), 32'd0);
    chk("bus_stable_under_e", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
